// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core data port, the host/DMA port, the SRAM and the arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  // core data port
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_rvalid;
  logic              core_stall;
  // host/DMA port
  logic              host_req;
  logic              host_we;
  logic              host_lock;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  // SRAM port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // arbiter side
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_rvalid, core_stall,
    input  host_req, host_we, host_lock, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // requesters and SRAM side
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_rvalid, core_stall,
    output host_req, host_we, host_lock, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-ported data SRAM between the core data port and the host/DMA
// port: round-robin on contention, bounded host lock, one access per cycle, and
// read data returned one cycle after issue to whichever port issued the read.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_LOCK = 4
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);
  localparam int unsigned LOCK_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  owner_e            rsp_owner;
  owner_e            rsp_owner_nxt;
  logic              rr_ptr;
  logic              rr_ptr_nxt;
  logic [LOCK_W-1:0] lock_cnt;
  logic [LOCK_W-1:0] lock_cnt_nxt;
  logic [DATA_W-1:0] core_rdata_q;
  logic [DATA_W-1:0] host_rdata_q;

  logic              core_rsp;
  logic              core_elig;
  logic              host_elig;
  logic              contended;
  logic              core_gnt;
  logic              host_gnt;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // Winner selection, SRAM issue mux, stall and next-state computation.
  always_comb begin
    core_gnt      = 1'b0;
    host_gnt      = 1'b0;
    win_we        = 1'b0;
    win_addr      = bus.host_addr;
    win_wdata     = bus.host_wdata;
    rr_ptr_nxt    = rr_ptr;
    lock_cnt_nxt  = lock_cnt;
    rsp_owner_nxt = OWN_NONE;

    // A core read blocks its own port during the response cycle; nothing issues in reset.
    core_rsp  = (rsp_owner == OWN_CORE);
    core_elig = bus.core_req && !core_rsp && !rst;
    host_elig = bus.host_req && !rst;
    contended = core_elig && host_elig;

    if (contended) begin
      if (bus.host_lock && (lock_cnt < LOCK_W'(MAX_LOCK))) begin
        host_gnt = 1'b1;
      end else if (lock_cnt == LOCK_W'(MAX_LOCK)) begin
        core_gnt = 1'b1;
      end else if (rr_ptr) begin
        host_gnt = 1'b1;
      end else begin
        core_gnt = 1'b1;
      end
    end else begin
      core_gnt = core_elig;
      host_gnt = host_elig;
    end

    if (core_gnt) begin
      win_we    = bus.core_we;
      win_addr  = bus.core_addr;
      win_wdata = bus.core_wdata;
    end else if (host_gnt) begin
      win_we    = bus.host_we;
    end

    // Round-robin pointer moves to the loser of a contended grant.
    if (contended) begin
      rr_ptr_nxt = core_gnt;
    end

    // Host lock streak: counts host grants made over a waiting core.
    if (core_gnt || !bus.host_lock || !core_elig) begin
      lock_cnt_nxt = '0;
    end else if (host_gnt && (lock_cnt < LOCK_W'(MAX_LOCK))) begin
      lock_cnt_nxt = lock_cnt + LOCK_W'(1);
    end

    if (core_gnt && !bus.core_we) begin
      rsp_owner_nxt = OWN_CORE;
    end else if (host_gnt && !bus.host_we) begin
      rsp_owner_nxt = OWN_HOST;
    end

    bus.mem_en      = core_gnt || host_gnt;
    bus.mem_we      = win_we;
    bus.mem_addr    = win_addr;
    bus.mem_wdata   = win_wdata;
    bus.host_gnt    = host_gnt;
    bus.core_stall  = bus.core_req && !(core_gnt && bus.core_we) && !core_rsp;
    bus.core_rvalid = core_rsp;
    bus.host_rvalid = (rsp_owner == OWN_HOST);
    bus.core_rdata  = core_rsp ? bus.mem_rdata : core_rdata_q;
    bus.host_rdata  = (rsp_owner == OWN_HOST) ? bus.mem_rdata : host_rdata_q;
  end

  // Arbitration state; reset drops any in-flight read response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_owner <= OWN_NONE;
      rr_ptr    <= 1'b0;
      lock_cnt  <= '0;
    end else begin
      rsp_owner <= rsp_owner_nxt;
      rr_ptr    <= rr_ptr_nxt;
      lock_cnt  <= lock_cnt_nxt;
    end
  end

  // Hold the last delivered read data for each port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rdata_q <= '0;
      host_rdata_q <= '0;
    end else begin
      if (rsp_owner == OWN_CORE) begin
        core_rdata_q <= bus.mem_rdata;
      end
      if (rsp_owner == OWN_HOST) begin
        host_rdata_q <= bus.mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vector table, multi-cycle corner sequences,
// then randomized traffic against a behavioural model of the sharing rules.
module tb_dmem_arbiter;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned MAX_LOCK = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous-read SRAM
  bit [15:0] sram [0:65535];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata      <= sram[bus.mem_addr];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.core_req   = 1'b0;
    bus.core_we    = 1'b0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_lock  = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
  endtask

  typedef struct {
    logic        c_req, c_we;
    logic [15:0] c_addr, c_wdata;
    logic        h_req, h_we, h_lock;
    logic [15:0] h_addr, h_wdata;
    logic        e_gnt, e_stall, e_en, e_we;
    logic [15:0] e_addr;
    logic        e_crv, e_hrv;
    logic [15:0] e_crd, e_hrd;
  } vec_t;

  function automatic vec_t v(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                             input logic hr, input logic hw, input logic hl, input logic [15:0] ha,
                             input logic [15:0] hd, input logic g, input logic s, input logic en,
                             input logic we, input logic [15:0] ad, input logic crv, input logic hrv,
                             input logic [15:0] crd, input logic [15:0] hrd);
    vec_t r;
    r.c_req = cr; r.c_we = cw; r.c_addr = ca; r.c_wdata = cd;
    r.h_req = hr; r.h_we = hw; r.h_lock = hl; r.h_addr = ha; r.h_wdata = hd;
    r.e_gnt = g; r.e_stall = s; r.e_en = en; r.e_we = we; r.e_addr = ad;
    r.e_crv = crv; r.e_hrv = hrv; r.e_crd = crd; r.e_hrd = hrd;
    return r;
  endfunction

  // ---------------- behavioural model for the random phase ----------------
  typedef enum int {W_NONE, W_CORE, W_HOST} who_e;
  typedef struct { bit to_core; logic [15:0] data; } rsp_t;

  rsp_t        rsp_q[$];
  bit   [15:0] shadow [0:15];
  bit          owed_host;     // next tie goes to the host
  int          streak;        // host grants in a row taken from a waiting core under lock
  logic [15:0] last_c, last_h;
  who_e        m_w;
  bit          m_ce, m_crsp;
  bit          p_cdone, p_hgnt;

  task automatic model_eval();
    bit          hrsp, he;
    logic [15:0] ea, ed;
    logic        ewe;
    m_crsp = (rsp_q.size() > 0) && rsp_q[0].to_core;
    hrsp   = (rsp_q.size() > 0) && !rsp_q[0].to_core;
    m_ce   = bus.core_req && !m_crsp;
    he     = bus.host_req;
    if (m_ce && he) begin
      if (bus.host_lock && streak < int'(MAX_LOCK)) m_w = W_HOST;
      else if (streak >= int'(MAX_LOCK))          m_w = W_CORE;
      else                                        m_w = owed_host ? W_HOST : W_CORE;
    end else if (m_ce) m_w = W_CORE;
    else if (he)       m_w = W_HOST;
    else               m_w = W_NONE;

    ewe = (m_w == W_CORE) ? bus.core_we : (m_w == W_HOST) ? bus.host_we : 1'b0;
    ea  = (m_w == W_CORE) ? bus.core_addr : bus.host_addr;
    ed  = (m_w == W_CORE) ? bus.core_wdata : bus.host_wdata;

    chk("rnd_gnt", 32'(bus.host_gnt), 32'(m_w == W_HOST));
    chk("rnd_stall", 32'(bus.core_stall),
        32'(bus.core_req && !(m_w == W_CORE && bus.core_we) && !m_crsp));
    chk("rnd_en", 32'(bus.mem_en), 32'(m_w != W_NONE));
    chk("rnd_we", 32'(bus.mem_we), 32'(ewe));
    if (m_w != W_NONE) chk("rnd_addr", 32'(bus.mem_addr), 32'(ea));
    if (ewe)           chk("rnd_wdata", 32'(bus.mem_wdata), 32'(ed));
    chk("rnd_crv", 32'(bus.core_rvalid), 32'(m_crsp));
    chk("rnd_hrv", 32'(bus.host_rvalid), 32'(hrsp));
    chk("rnd_crd", 32'(bus.core_rdata), 32'(m_crsp ? rsp_q[0].data : last_c));
    chk("rnd_hrd", 32'(bus.host_rdata), 32'(hrsp ? rsp_q[0].data : last_h));
  endtask

  task automatic model_commit();
    logic [15:0] a;
    logic        we;
    rsp_t        r;
    p_cdone = (m_w == W_CORE && bus.core_we) || m_crsp;
    p_hgnt  = (m_w == W_HOST);
    if (rsp_q.size() > 0) begin
      if (rsp_q[0].to_core) last_c = rsp_q[0].data;
      else                  last_h = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end
    if (m_w != W_NONE) begin
      a  = (m_w == W_CORE) ? bus.core_addr : bus.host_addr;
      we = (m_w == W_CORE) ? bus.core_we : bus.host_we;
      if (we) shadow[a[3:0]] = (m_w == W_CORE) ? bus.core_wdata : bus.host_wdata;
      else begin
        r.to_core = (m_w == W_CORE);
        r.data    = shadow[a[3:0]];
        rsp_q.push_back(r);
      end
    end
    if (m_ce && bus.host_req) owed_host = (m_w == W_CORE);
    if (m_w == W_CORE || !bus.host_lock || !m_ce) streak = 0;
    else if (m_w == W_HOST && streak < int'(MAX_LOCK)) streak++;
  endtask

  vec_t tbl[16];

  initial begin
    logic exp_g [9];
    logic exp_s [9];
    int   hi;
    logic cdone;

    tbl[0]  = v(0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000, 0,0,16'h0000,16'h0000);
    tbl[1]  = v(1,1,16'h0010,16'hBEEF, 0,0,0,16'h0000,16'h0000, 0,0,1,1,16'h0010, 0,0,16'h0000,16'h0000);
    tbl[2]  = v(1,0,16'h0010,16'h0000, 0,0,0,16'h0000,16'h0000, 0,1,1,0,16'h0010, 0,0,16'h0000,16'h0000);
    tbl[3]  = v(1,0,16'h0010,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000, 1,0,16'hBEEF,16'h0000);
    tbl[4]  = v(0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000, 0,0,16'hBEEF,16'h0000);
    tbl[5]  = v(0,0,16'h0000,16'h0000, 1,1,0,16'h0020,16'h1234, 1,0,1,1,16'h0020, 0,0,16'hBEEF,16'h0000);
    tbl[6]  = v(0,0,16'h0000,16'h0000, 1,0,0,16'h0020,16'h0000, 1,0,1,0,16'h0020, 0,0,16'hBEEF,16'h0000);
    tbl[7]  = v(0,0,16'h0000,16'h0000, 1,0,0,16'h0010,16'h0000, 1,0,1,0,16'h0010, 0,1,16'hBEEF,16'h1234);
    tbl[8]  = v(0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000, 0,1,16'hBEEF,16'hBEEF);
    tbl[9]  = v(0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000, 0,0,16'hBEEF,16'hBEEF);
    tbl[10] = v(1,0,16'h0020,16'h0000, 1,1,0,16'h0020,16'h5678, 0,1,1,0,16'h0020, 0,0,16'hBEEF,16'hBEEF);
    tbl[11] = v(1,0,16'h0020,16'h0000, 1,1,0,16'h0020,16'h5678, 1,0,1,1,16'h0020, 1,0,16'h1234,16'hBEEF);
    tbl[12] = v(1,1,16'h0030,16'hAAAA, 1,1,0,16'h0031,16'hBBBB, 1,1,1,1,16'h0031, 0,0,16'h1234,16'hBEEF);
    tbl[13] = v(1,1,16'h0030,16'hAAAA, 0,0,0,16'h0000,16'h0000, 0,0,1,1,16'h0030, 0,0,16'h1234,16'hBEEF);
    tbl[14] = v(0,0,16'h0000,16'h0000, 1,0,0,16'h0030,16'h0000, 1,0,1,0,16'h0030, 0,0,16'h1234,16'hBEEF);
    tbl[15] = v(0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000, 0,1,16'h1234,16'hAAAA);

    // Reset state
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_crv", 32'(bus.core_rvalid), 32'd0);
    chk("rst_hrv", 32'(bus.host_rvalid), 32'd0);
    chk("rst_crd", 32'(bus.core_rdata), 32'd0);
    chk("rst_hrd", 32'(bus.host_rdata), 32'd0);
    rst = 1'b0;

    // Directed vector table, one row per cycle from reset
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      bus.core_req  = tbl[i].c_req;  bus.core_we    = tbl[i].c_we;
      bus.core_addr = tbl[i].c_addr; bus.core_wdata = tbl[i].c_wdata;
      bus.host_req  = tbl[i].h_req;  bus.host_we    = tbl[i].h_we;
      bus.host_lock = tbl[i].h_lock; bus.host_addr  = tbl[i].h_addr;
      bus.host_wdata = tbl[i].h_wdata;
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", i),   32'(bus.host_gnt),    32'(tbl[i].e_gnt));
      chk($sformatf("tbl%0d_stall", i), 32'(bus.core_stall),  32'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_en", i),    32'(bus.mem_en),      32'(tbl[i].e_en));
      chk($sformatf("tbl%0d_we", i),    32'(bus.mem_we),      32'(tbl[i].e_we));
      if (tbl[i].e_en) chk($sformatf("tbl%0d_addr", i), 32'(bus.mem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_crv", i),   32'(bus.core_rvalid), 32'(tbl[i].e_crv));
      chk($sformatf("tbl%0d_hrv", i),   32'(bus.host_rvalid), 32'(tbl[i].e_hrv));
      chk($sformatf("tbl%0d_crd", i),   32'(bus.core_rdata),  32'(tbl[i].e_crd));
      chk($sformatf("tbl%0d_hrd", i),   32'(bus.host_rdata),  32'(tbl[i].e_hrd));
    end

    // Host lock: 8 host writes under lock against a waiting core write
    exp_g = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
    exp_s = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    hi = 0;
    cdone = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      bus.host_req   = (hi < 8);
      bus.host_we    = 1'b1;
      bus.host_lock  = 1'b1;
      bus.host_addr  = 16'h0100 + 16'(hi);
      bus.host_wdata = 16'hC000 + 16'(hi);
      bus.core_req   = !cdone;
      bus.core_we    = 1'b1;
      bus.core_addr  = 16'h0200;
      bus.core_wdata = 16'h5555;
      @(negedge clk);
      chk($sformatf("lock%0d_gnt", k), 32'(bus.host_gnt), 32'(exp_g[k]));
      chk($sformatf("lock%0d_stall", k), 32'(bus.core_stall), 32'(exp_s[k]));
      if (bus.host_gnt) hi++;
      if (bus.core_req && bus.mem_en && !bus.host_gnt) cdone = 1'b1;
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    chk("lock_core_word", 32'(sram[16'h0200]), 32'h5555);
    chk("lock_last_host_word", 32'(sram[16'h0107]), 32'hC007);

    // Pipelined host reads of 0x0000..0x0003 (seeded through the host port)
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      bus.host_req = 1'b1; bus.host_we = 1'b1;
      bus.host_addr = 16'(k); bus.host_wdata = 16'hA000 + 16'(k);
      @(negedge clk);
      chk($sformatf("pre%0d_gnt", k), 32'(bus.host_gnt), 32'd1);
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      bus.host_req = (k < 4); bus.host_we = 1'b0; bus.host_addr = 16'(k);
      @(negedge clk);
      chk($sformatf("pipe%0d_gnt", k), 32'(bus.host_gnt), 32'(k < 4));
      chk($sformatf("pipe%0d_hrv", k), 32'(bus.host_rvalid), 32'(k >= 1 && k <= 4));
      if (k >= 1) chk($sformatf("pipe%0d_hrd", k), 32'(bus.host_rdata),
                      32'(16'hA000 + 16'(k >= 4 ? 3 : k - 1)));
    end

    // Reset asserted mid-cycle while a core read response is in flight
    @(posedge clk); #1;
    drive_idle();
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 16'h0010;
    @(posedge clk); #1;
    chk("rstmid_pre_crv", 32'(bus.core_rvalid), 32'd1);
    chk("rstmid_pre_crd", 32'(bus.core_rdata), 32'hBEEF);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_crv", 32'(bus.core_rvalid), 32'd0);
    chk("rstmid_hrv", 32'(bus.host_rvalid), 32'd0);
    chk("rstmid_crd", 32'(bus.core_rdata), 32'd0);
    chk("rstmid_hrd", 32'(bus.host_rdata), 32'd0);
    chk("rstmid_en", 32'(bus.mem_en), 32'd0);
    chk("rstmid_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("rstpost%0d_crv", k), 32'(bus.core_rvalid), 32'd0);
    end

    // Randomized traffic against the behavioural model
    owed_host = 1'b0;
    streak    = 0;
    last_c    = 16'h0000;
    last_h    = 16'h0000;
    p_cdone   = 1'b0;
    p_hgnt    = 1'b0;
    m_w       = W_NONE;
    rsp_q.delete();
    for (int a = 0; a < 16; a++) shadow[a] = sram[a];
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (cyc > 0) model_commit();
      if (!bus.core_req || p_cdone) begin
        bus.core_req = ($urandom_range(0, 99) < 60);
        bus.core_we    = ($urandom_range(0, 2) == 0);
        bus.core_addr  = 16'($urandom_range(0, 15));
        bus.core_wdata = 16'($urandom);
      end
      if (!bus.host_req || p_hgnt) begin
        bus.host_req = ($urandom_range(0, 99) < 60);
        bus.host_we    = ($urandom_range(0, 1) == 0);
        bus.host_addr  = 16'($urandom_range(0, 15));
        bus.host_wdata = 16'($urandom);
      end
      if ($urandom_range(0, 99) < 10) bus.host_lock = ~bus.host_lock;
      @(negedge clk);
      model_eval();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
